pc_seq_unit: RTL and testbench

- Parametrised program-counter sequencer for the CPU core. Successor to the current PC block.
- Holds the PC and a saturating fetch-offset register.
- Adds a 2-byte operand capture state machine, a one-shot halt-skip (HALT bug) mode, and error/overflow pulses.
- Sits between the instruction decoder (commands), the data bus (operands) and the memory address mux (pc / pc_w_offset).

---
 rtl/pc_seq_unit.sv | 139 +++++++++++++
 tb/tb_pc_seq_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: PC with a saturating fetch offset, a 2-byte
// operand capture buffer, one-shot halt-skip and error/overflow pulses.
module pc_seq_unit #(
    parameter int                ADDR_W    = 16,
    parameter int                OFS_W     = 2,
    parameter logic [ADDR_W-1:0] RESET_VEC = 'h0100,
    parameter logic [ADDR_W-1:0] INT_BASE  = 'h0040,
    parameter int                VEC_SHIFT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        pc_cmd,
    input  logic [1:0]        offset_cmd,
    input  logic [2:0]        rst_idx,
    input  logic [2:0]        int_idx,
    input  logic [7:0]        data_bus,
    input  logic [ADDR_W-1:0] reg_file_in,
    input  logic              op_capture,
    input  logic              op_clear,
    input  logic              halt_skip,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_w_offset,
    output logic [15:0]       operand,
    output logic              op_valid,
    output logic              offset_sat,
    output logic              halt_armed,
    output logic              abs_err,
    output logic              op_ovf
);

    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_INCR = 3'd1,
        CMD_RST  = 3'd2,
        CMD_INT  = 3'd3,
        CMD_ZERO = 3'd4,
        CMD_ABS  = 3'd5,
        CMD_REL  = 3'd6,
        CMD_REG  = 3'd7
    } pc_cmd_t;

    typedef enum logic [1:0] {
        OP_EMPTY = 2'd0,
        OP_LO    = 2'd1,
        OP_FULL  = 2'd2
    } op_state_t;

    localparam logic [OFS_W-1:0] OFS_MAX = '1;

    pc_cmd_t           cmd;
    op_state_t         op_state;
    logic [OFS_W-1:0]  offset;
    logic [7:0]        op_lo;
    logic [7:0]        op_hi;
    logic [ADDR_W-1:0] rst_target;
    logic [ADDR_W-1:0] int_target;
    logic [ADDR_W-1:0] rel_target;
    logic              abs_ok;
    logic              halt_consume;

    assign cmd          = pc_cmd_t'(pc_cmd);
    assign pc_w_offset  = pc + ADDR_W'(offset);
    assign rst_target   = ADDR_W'(rst_idx) << VEC_SHIFT;
    assign int_target   = INT_BASE + (ADDR_W'(int_idx) << VEC_SHIFT);
    assign rel_target   = pc_w_offset + {{(ADDR_W-8){data_bus[7]}}, data_bus};
    assign abs_ok       = (cmd == CMD_ABS) && (op_state == OP_FULL);
    // An arming request in the same cycle as INCR already suppresses that INCR.
    assign halt_consume = (cmd == CMD_INCR) && (halt_armed || halt_skip);

    assign operand    = {op_hi, op_lo};
    assign op_valid   = (op_state == OP_FULL);
    assign offset_sat = (offset == OFS_MAX);

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking assignments would let later statements see half-updated state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_VEC;
            offset     <= '0;
            op_state   <= OP_EMPTY;
            op_lo      <= '0;
            op_hi      <= '0;
            halt_armed <= 1'b0;
            abs_err    <= 1'b0;
            op_ovf     <= 1'b0;
        end else begin
            op_ovf  <= 1'b0;
            abs_err <= (cmd == CMD_ABS) && !abs_ok;

            case (cmd)
                CMD_HOLD: pc <= pc;
                CMD_INCR: pc <= halt_consume ? pc : pc_w_offset + 1'b1;
                CMD_RST:  pc <= rst_target;
                CMD_INT:  pc <= int_target;
                CMD_ZERO: pc <= '0;
                CMD_ABS:  pc <= abs_ok ? ADDR_W'(operand) : pc;
                CMD_REL:  pc <= rel_target;
                CMD_REG:  pc <= reg_file_in;
                default:  pc <= pc;
            endcase

            if (cmd != CMD_HOLD) begin
                offset <= '0;
            end else begin
                case (offset_cmd)
                    2'd1:    if (offset != OFS_MAX) offset <= offset + 1'b1;
                    2'd2:    offset <= '0;
                    default: offset <= offset;
                endcase
            end

            if (cmd == CMD_INCR) begin
                halt_armed <= 1'b0;
            end else if (halt_skip) begin
                halt_armed <= 1'b1;
            end

            // Clear and a successful ABS both drain the buffer and drop any capture.
            if (op_clear || abs_ok) begin
                op_state <= OP_EMPTY;
                op_lo    <= '0;
                op_hi    <= '0;
            end else if (op_capture) begin
                case (op_state)
                    OP_EMPTY: begin
                        op_lo    <= data_bus;
                        op_state <= OP_LO;
                    end
                    OP_LO: begin
                        op_hi    <= data_bus;
                        op_state <= OP_FULL;
                    end
                    default: op_ovf <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed test-plan sequences plus
// randomized traffic, checked every cycle against a queue-based model.
module tb_pc_seq_unit;

    localparam int ADDR_W = 16;
    localparam int MASK   = 'hFFFF;

    localparam logic [2:0] HOLD = 3'd0, INCR = 3'd1, RST = 3'd2, INT = 3'd3,
                           ZERO = 3'd4, ABS = 3'd5, REL = 3'd6, REG = 3'd7;

    logic              clock;
    logic              reset;
    logic [2:0]        pc_cmd;
    logic [1:0]        offset_cmd;
    logic [2:0]        rst_idx;
    logic [2:0]        int_idx;
    logic [7:0]        data_bus;
    logic [ADDR_W-1:0] reg_file_in;
    logic              op_capture;
    logic              op_clear;
    logic              halt_skip;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_w_offset;
    logic [15:0]       operand;
    logic              op_valid;
    logic              offset_sat;
    logic              halt_armed;
    logic              abs_err;
    logic              op_ovf;

    pc_seq_unit dut (
        .clock       (clock),
        .reset       (reset),
        .pc_cmd      (pc_cmd),
        .offset_cmd  (offset_cmd),
        .rst_idx     (rst_idx),
        .int_idx     (int_idx),
        .data_bus    (data_bus),
        .reg_file_in (reg_file_in),
        .op_capture  (op_capture),
        .op_clear    (op_clear),
        .halt_skip   (halt_skip),
        .pc          (pc),
        .pc_w_offset (pc_w_offset),
        .operand     (operand),
        .op_valid    (op_valid),
        .offset_sat  (offset_sat),
        .halt_armed  (halt_armed),
        .abs_err     (abs_err),
        .op_ovf      (op_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: plain integers and a byte queue standing in for the buffer.
    int  m_pc;
    int  m_ofs;
    bit  m_halt;
    bit  m_abs_err;
    bit  m_ovf;
    byte unsigned m_buf[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_operand();
        int v = 0;
        if (m_buf.size() > 0) v = int'(m_buf[0]);
        if (m_buf.size() > 1) v = v | (int'(m_buf[1]) << 8);
        return v;
    endfunction

    task automatic model_reset();
        m_pc      = 'h0100;
        m_ofs     = 0;
        m_halt    = 1'b0;
        m_abs_err = 1'b0;
        m_ovf     = 1'b0;
        m_buf.delete();
    endtask

    task automatic model_update();
        int  pwo;
        int  disp;
        bit  full;
        int  npc;
        full = (m_buf.size() == 2);
        pwo  = (m_pc + m_ofs) & MASK;
        disp = (data_bus >= 8'd128) ? int'(data_bus) - 256 : int'(data_bus);
        npc  = m_pc;
        m_abs_err = 1'b0;
        m_ovf     = 1'b0;
        case (pc_cmd)
            INCR: if (!(m_halt || halt_skip)) npc = pwo + 1;
            RST:  npc = int'(rst_idx) * 8;
            INT:  npc = 'h40 + int'(int_idx) * 8;
            ZERO: npc = 0;
            ABS:  if (full) npc = m_operand(); else m_abs_err = 1'b1;
            REL:  npc = pwo + disp;
            REG:  npc = int'(reg_file_in);
            default: ;
        endcase
        if (pc_cmd != HOLD) m_ofs = 0;
        else if (offset_cmd == 2'd1) m_ofs = (m_ofs < 3) ? m_ofs + 1 : 3;
        else if (offset_cmd == 2'd2) m_ofs = 0;
        if (pc_cmd == INCR) m_halt = 1'b0;
        else if (halt_skip) m_halt = 1'b1;
        if (op_clear || (pc_cmd == ABS && full)) m_buf.delete();
        else if (op_capture) begin
            if (m_buf.size() < 2) m_buf.push_back(data_bus);
            else m_ovf = 1'b1;
        end
        m_pc = npc & MASK;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("pc",          int'(pc),          m_pc);
            check("pc_w_offset", int'(pc_w_offset), (m_pc + m_ofs) & MASK);
            check("operand",     int'(operand),     m_operand());
            check("op_valid",    int'(op_valid),    int'(m_buf.size() == 2));
            check("offset_sat",  int'(offset_sat),  int'(m_ofs == 3));
            check("halt_armed",  int'(halt_armed),  int'(m_halt));
            check("abs_err",     int'(abs_err),     int'(m_abs_err));
            check("op_ovf",      int'(op_ovf),      int'(m_ovf));
        end
    end

    task automatic idle();
        pc_cmd      = HOLD;
        offset_cmd  = 2'd0;
        rst_idx     = 3'd0;
        int_idx     = 3'd0;
        data_bus    = 8'h00;
        reg_file_in = '0;
        op_capture  = 1'b0;
        op_clear    = 1'b0;
        halt_skip   = 1'b0;
    endtask

    // One clock: model advances on the same edge as the DUT, checks follow the falling edge.
    task automatic tick();
        @(posedge clock);
        model_update();
        @(negedge clock);
        #1;
        idle();
    endtask

    task automatic capture(input logic [7:0] b);
        op_capture = 1'b1;
        data_bus   = b;
        tick();
    endtask

    initial begin
        int r;
        idle();
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        chk_en = 1'b1;
        check("reset pc",          int'(pc),          'h0100);
        check("reset pc_w_offset", int'(pc_w_offset), 'h0100);
        check("reset op_valid",    int'(op_valid),    0);
        check("reset halt_armed",  int'(halt_armed),  0);

        // Asynchronous reset with a half-captured operand.
        capture(8'hA5);
        check("lo captured", int'(operand), 'h00A5);
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("async reset operand", int'(operand), 0);
        check("async reset pc",      int'(pc),      'h0100);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_en = 1'b1;

        // Offset saturation, then INCR through pc_w_offset.
        repeat (5) begin
            offset_cmd = 2'd1;
            tick();
        end
        check("offset_sat",      int'(offset_sat),  1);
        check("pwo saturated",   int'(pc_w_offset), 'h0103);
        pc_cmd = INCR;
        tick();
        check("incr pc",         int'(pc),          'h0104);
        check("incr clears ofs", int'(pc_w_offset), 'h0104);

        // Two-byte capture and ABS jump.
        capture(8'h34);
        capture(8'h12);
        check("op_valid full", int'(op_valid), 1);
        check("operand full",  int'(operand),  'h1234);
        pc_cmd = ABS;
        tick();
        check("abs pc",       int'(pc),       'h1234);
        check("abs drains",   int'(op_valid), 0);

        // Overflow: third capture while FULL pulses op_ovf once.
        capture(8'h11);
        capture(8'h22);
        capture(8'h33);
        check("op_ovf pulse", int'(op_ovf),  1);
        check("ovf keeps",    int'(operand), 'h2211);
        tick();
        check("op_ovf low",   int'(op_ovf),  0);

        // ABS with a single byte fails; clear beats capture.
        op_clear = 1'b1;
        tick();
        capture(8'h77);
        pc_cmd = ABS;
        tick();
        check("abs_err pulse", int'(abs_err), 1);
        check("abs_err hold",  int'(pc),      'h1234);
        tick();
        check("abs_err low",   int'(abs_err), 0);
        op_clear   = 1'b1;
        op_capture = 1'b1;
        data_bus   = 8'h99;
        tick();
        check("clear wins",    int'(operand), 0);

        // ABS + capture in LO: ABS fails, capture fills the buffer.
        capture(8'h01);
        pc_cmd = ABS;
        op_capture = 1'b1;
        data_bus   = 8'h02;
        tick();
        check("abs lo err",    int'(abs_err),  1);
        check("abs lo full",   int'(operand),  'h0201);

        // Relative jumps, including address wrap.
        pc_cmd = REG;
        reg_file_in = 16'h0150;
        tick();
        offset_cmd = 2'd1;
        tick();
        pc_cmd   = REL;
        data_bus = 8'hFE;
        tick();
        check("rel back", int'(pc), 'h014F);
        pc_cmd = REG;
        reg_file_in = 16'hFFF0;
        tick();
        pc_cmd   = REL;
        data_bus = 8'h7F;
        tick();
        check("rel wrap", int'(pc), 'h006F);

        // Vectors and halt-skip.
        pc_cmd  = RST;
        rst_idx = 3'd7;
        tick();
        check("rst vec", int'(pc), 'h0038);
        pc_cmd  = INT;
        int_idx = 3'd2;
        tick();
        check("int vec", int'(pc), 'h0050);
        halt_skip = 1'b1;
        tick();
        check("halt armed", int'(halt_armed), 1);
        pc_cmd = INCR;
        tick();
        check("halt skip pc",   int'(pc),         'h0050);
        check("halt consumed",  int'(halt_armed), 0);
        pc_cmd = INCR;
        tick();
        check("incr after skip", int'(pc), 'h0051);
        pc_cmd    = INCR;
        halt_skip = 1'b1;
        tick();
        check("skip+incr pc",   int'(pc),         'h0051);
        check("skip+incr flag", int'(halt_armed), 0);

        // Randomized traffic, HOLD-biased so offsets and operands accumulate.
        for (int i = 0; i < 3000; i++) begin
            r           = $urandom_range(0, 15);
            pc_cmd      = (r < 8) ? HOLD : 3'(r - 8);
            offset_cmd  = 2'($urandom_range(0, 3));
            rst_idx     = 3'($urandom_range(0, 7));
            int_idx     = 3'($urandom_range(0, 7));
            data_bus    = 8'($urandom_range(0, 255));
            reg_file_in = 16'($urandom_range(0, 'hFFFF));
            op_capture  = ($urandom_range(0, 1) == 1);
            op_clear    = ($urandom_range(0, 9) == 0);
            halt_skip   = ($urandom_range(0, 7) == 0);
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
